// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO UART transmitter: address window, register
// selects, STATUS bit layout and serializer state encoding.
package mmio_pkg;

  localparam logic [31:0] MMIO_BASE = 32'hffff_0000;
  localparam logic [31:0] MMIO_HIGH = 32'hffff_0010;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int unsigned STAT_EMPTY   = 0;
  localparam int unsigned STAT_FULL    = 1;
  localparam int unsigned STAT_BUSY    = 2;
  localparam int unsigned STAT_CNT_LSB = 3;
  localparam int unsigned STAT_CNT_MSB = 6;
  localparam int unsigned STAT_OVF     = 7;

  localparam int unsigned DIV_W  = 16;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

  // A zero divisor would never advance the bit timer, so it is treated as 1.
  function automatic logic [DIV_W-1:0] div_sanitize(input logic [DIV_W-1:0] d);
    return (d == '0) ? DIV_W'(1) : d;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a push is accepted while full when
// a pop happens in the same cycle.
module sync_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: DATA/STATUS/DIV registers, a transmit
// FIFO and a serializer that runs frames back to back while data is queued.
module mmio_uart_tx
  import mmio_pkg::*;
#(
  parameter int unsigned       FIFO_DEPTH = 4,
  parameter logic [DIV_W-1:0]  DIV_RESET  = 16'd868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [1:0]  regsel,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        tx
);

  localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CNT_F = STAT_CNT_MSB - STAT_CNT_LSB + 1;

  tx_state_e         state, state_d;
  logic [DIV_W-1:0]  clk_cnt, clk_cnt_d;
  logic [2:0]        bit_cnt, bit_cnt_d;
  logic [BYTE_W-1:0] shreg, shreg_d;
  logic [DIV_W-1:0]  div_lat, div_lat_d;
  logic [DIV_W-1:0]  div_q;
  logic              ovf;
  logic              tx_d;
  logic              bit_done;

  logic              data_wr;
  logic              push;
  logic              pop;
  logic              ovf_set;
  logic [BYTE_W-1:0] fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [CNT_F-1:0]  cnt_field;
  logic [31:0]       status;
  logic              unused_wdata;

  assign unused_wdata = ^writedata[31:16];

  sync_fifo #(
    .WIDTH (BYTE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (writedata[BYTE_W-1:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // A write into a full FIFO still lands if the serializer pops this cycle.
  assign data_wr = we && (regsel == REG_DATA);
  assign push    = data_wr && (!fifo_full || pop);
  assign ovf_set = data_wr && fifo_full && !pop;

  // Overflow set wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf   <= 1'b0;
      div_q <= div_sanitize(DIV_RESET);
    end else begin
      if (ovf_set) ovf <= 1'b1;
      else if (we && (regsel == REG_STATUS) && writedata[STAT_OVF]) ovf <= 1'b0;
      if (we && (regsel == REG_DIV)) div_q <= div_sanitize(writedata[DIV_W-1:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      div_lat <= div_sanitize(DIV_RESET);
      tx      <= 1'b1;
    end else begin
      state   <= state_d;
      clk_cnt <= clk_cnt_d;
      bit_cnt <= bit_cnt_d;
      shreg   <= shreg_d;
      div_lat <= div_lat_d;
      tx      <= tx_d;
    end
  end

  // Next-state and registered-output logic; tx_d follows the state being entered.
  always_comb begin
    state_d   = state;
    clk_cnt_d = clk_cnt;
    bit_cnt_d = bit_cnt;
    shreg_d   = shreg;
    div_lat_d = div_lat;
    pop       = 1'b0;
    tx_d      = 1'b1;
    bit_done  = (clk_cnt == div_lat - DIV_W'(1));

    unique case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_d   = S_START;
          shreg_d   = fifo_dout;
          div_lat_d = div_q;
          clk_cnt_d = '0;
        end
      end
      S_START: begin
        if (bit_done) begin
          state_d   = S_DATA;
          clk_cnt_d = '0;
          bit_cnt_d = '0;
        end else begin
          clk_cnt_d = clk_cnt + DIV_W'(1);
        end
      end
      S_DATA: begin
        if (bit_done) begin
          clk_cnt_d = '0;
          if (bit_cnt == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_cnt_d = bit_cnt + 3'd1;
            shreg_d   = shreg >> 1;
          end
        end else begin
          clk_cnt_d = clk_cnt + DIV_W'(1);
        end
      end
      S_STOP: begin
        if (bit_done) begin
          clk_cnt_d = '0;
          if (!fifo_empty) begin
            pop       = 1'b1;
            state_d   = S_START;
            shreg_d   = fifo_dout;
            div_lat_d = div_q;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt + DIV_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_START)     tx_d = 1'b0;
    else if (state_d == S_DATA) tx_d = shreg_d[0];
  end

  // Count saturates so a completely full 16-deep FIFO does not read as zero.
  assign cnt_field = (int'(fifo_count) >= (1 << CNT_F)) ? '1 : CNT_F'(fifo_count);

  always_comb begin
    status                            = '0;
    status[STAT_EMPTY]                = fifo_empty;
    status[STAT_FULL]                 = fifo_full;
    status[STAT_BUSY]                 = (state != S_IDLE);
    status[STAT_CNT_MSB:STAT_CNT_LSB] = cnt_field;
    status[STAT_OVF]                  = ovf;
  end

  always_comb begin
    readdata = '0;
    unique case (regsel)
      REG_STATUS:         readdata = status;
      REG_DIV:            readdata = {16'b0, div_q};
      REG_DATA, REG_RSVD: readdata = '0;
      default:            readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: directed scenarios plus random register traffic,
// checked every cycle against a frame-timeline model of the transmitter.
module tb_mmio_uart_tx;
  import mmio_pkg::*;

  localparam int unsigned DEPTH   = 4;
  localparam logic [15:0] DIV_RST = 16'd868;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [1:0]  regsel;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        tx;

  mmio_uart_tx #(
    .FIFO_DEPTH (DEPTH),
    .DIV_RESET  (DIV_RST)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .we        (we),
    .regsel    (regsel),
    .writedata (writedata),
    .readdata  (readdata),
    .tx        (tx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int edge_n   = 0;

  // Model: bytes waiting to start (arrival edge + value) and the latest frame.
  int pend_push[$];
  int pend_byte[$];
  int cur_start = 0;
  int cur_div   = 1;
  int cur_byte  = 0;
  int cur_end   = 0;
  int m_div     = int'(DIV_RST);
  bit m_ovf     = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%0h exp=%0h edge=%0d", tag, got, exp, edge_n);
  endtask

  // A byte starts at max(arrival+1, end of previous frame) using the divisor in force then.
  task automatic model_edge(input logic rst, input logic w, input logic [1:0] rs, input logic [31:0] wd);
    int s;
    if (rst) begin
      pend_push.delete();
      pend_byte.delete();
      cur_end = 0;
      m_div   = int'(DIV_RST);
      m_ovf   = 1'b0;
      return;
    end
    if (pend_push.size() > 0) begin
      s = (pend_push[0] + 1 > cur_end) ? pend_push[0] + 1 : cur_end;
      if (s <= edge_n) begin
        cur_start = edge_n;
        cur_div   = m_div;
        cur_byte  = pend_byte[0];
        cur_end   = edge_n + 10 * m_div;
        void'(pend_push.pop_front());
        void'(pend_byte.pop_front());
      end
    end
    if (w) begin
      if (rs == REG_DATA) begin
        if (pend_push.size() < int'(DEPTH)) begin
          pend_push.push_back(edge_n);
          pend_byte.push_back(int'(wd[7:0]));
        end else begin
          m_ovf = 1'b1;
        end
      end else if (rs == REG_STATUS) begin
        if (wd[7]) m_ovf = 1'b0;
      end else if (rs == REG_DIV) begin
        m_div = (wd[15:0] == 16'd0) ? 1 : int'(wd[15:0]);
      end
    end
  endtask

  function automatic logic exp_tx();
    int k;
    if (cur_end > edge_n) begin
      k = (edge_n - cur_start) / cur_div;
      if (k == 0) return 1'b0;
      if (k == 9) return 1'b1;
      return 1'((cur_byte >> (k - 1)) & 1);
    end
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_reg(input logic [1:0] rs);
    int          c;
    logic [31:0] v;
    c = pend_push.size();
    v = '0;
    if (rs == REG_STATUS) begin
      v[7]   = m_ovf;
      v[6:3] = 4'(c);
      v[2]   = (cur_end > edge_n);
      v[1]   = (c == int'(DEPTH));
      v[0]   = (c == 0);
    end else if (rs == REG_DIV) begin
      v = 32'(m_div);
    end
    return v;
  endfunction

  // One clock: drive, advance model, then check tx and one register (rotating).
  task automatic step(input logic rst, input logic w, input logic [1:0] rs, input logic [31:0] wd);
    logic [1:0] rr;
    string      tag;
    reset     = rst;
    we        = w;
    regsel    = rs;
    writedata = wd;
    @(posedge clk);
    edge_n++;
    model_edge(rst, w, rs, wd);
    #1;
    reset = 1'b0;
    we    = 1'b0;
    rr    = 2'(edge_n);
    regsel = rr;
    #1;
    check("tx", 32'(tx), 32'(exp_tx()));
    case (rr)
      2'd0:    tag = "rd_data";
      2'd1:    tag = "rd_status";
      2'd2:    tag = "rd_div";
      default: tag = "rd_rsvd";
    endcase
    check(tag, readdata, exp_reg(rr));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, REG_DATA, 32'h0);
  endtask

  task automatic peek(input logic [1:0] rs, output logic [31:0] v);
    regsel = rs;
    #1;
    v = readdata;
  endtask

  initial begin
    logic [31:0] v;
    bit          force_div;
    int          r;

    reset = 1'b1; we = 1'b0; regsel = 2'd0; writedata = '0;
    step(1'b1, 1'b0, REG_DATA, 32'h0);
    step(1'b1, 1'b1, REG_DATA, 32'h0000_00aa);
    check("reset_tx", 32'(tx), 32'd1);
    peek(REG_STATUS, v); check("reset_status", v, 32'h0000_0001);
    peek(REG_DIV, v);    check("reset_div", v, 32'd868);
    idle(3);

    // 0x55 at 4 clocks per bit; tx falls one edge after the write.
    step(1'b0, 1'b1, REG_DIV, 32'd4);
    step(1'b0, 1'b1, REG_DATA, 32'h0000_0055);
    check("pre_start_tx", 32'(tx), 32'd1);
    step(1'b0, 1'b0, REG_DATA, 32'h0);
    check("latency_tx", 32'(tx), 32'd0);
    idle(45);

    // Fill while busy: fifth byte dropped, overflow flagged.
    step(1'b0, 1'b1, REG_DIV, 32'd2);
    step(1'b0, 1'b1, REG_DATA, 32'h0000_00ff);
    for (int i = 1; i <= 5; i++) step(1'b0, 1'b1, REG_DATA, 32'(i));
    peek(REG_STATUS, v); check("fill_status", v, 32'h0000_00a6);
    idle(110);
    step(1'b0, 1'b1, REG_STATUS, 32'h0000_007f);
    peek(REG_STATUS, v); check("ovf_keep", v, 32'h0000_0081);
    step(1'b0, 1'b1, REG_STATUS, 32'h0000_0080);
    peek(REG_STATUS, v); check("ovf_clear", v, 32'h0000_0001);

    // Zero divisor reads back as 1.
    step(1'b0, 1'b1, REG_DIV, 32'hffff_0000);
    peek(REG_DIV, v); check("div_zero", v, 32'd1);
    step(1'b0, 1'b1, REG_DATA, 32'h0000_00c3);
    idle(15);

    // Divisor change mid-frame applies to the next frame only.
    step(1'b0, 1'b1, REG_DIV, 32'd4);
    step(1'b0, 1'b1, REG_DATA, 32'h0000_00a5);
    idle(10);
    step(1'b0, 1'b1, REG_DIV, 32'd8);
    peek(REG_DIV, v); check("div_change", v, 32'd8);
    step(1'b0, 1'b1, REG_DATA, 32'h0000_003c);
    idle(130);

    // Reset during data bit 3 with two bytes queued.
    step(1'b0, 1'b1, REG_DIV, 32'd4);
    step(1'b0, 1'b1, REG_DATA, 32'h0000_0000);
    step(1'b0, 1'b1, REG_DATA, 32'h0000_0011);
    step(1'b0, 1'b1, REG_DATA, 32'h0000_0022);
    idle(16);
    check("pre_reset_tx", 32'(tx), 32'd0);
    step(1'b1, 1'b0, REG_DATA, 32'h0);
    check("abort_tx", 32'(tx), 32'd1);
    peek(REG_STATUS, v); check("abort_status", v, 32'h0000_0001);
    idle(100);

    // Random register traffic.
    force_div = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      r = int'($urandom_range(0, 999));
      if (force_div) begin
        step(1'b0, 1'b1, REG_DIV, {16'($urandom), 16'($urandom_range(0, 5))});
        force_div = 1'b0;
      end else if (r < 4) begin
        step(1'b1, 1'($urandom), 2'($urandom), $urandom());
        force_div = 1'b1;
      end else if (r < 250) begin
        step(1'b0, 1'b1, REG_DATA, $urandom());
      end else if (r < 280) begin
        step(1'b0, 1'b1, REG_DIV, {16'($urandom), 16'($urandom_range(0, 6))});
      end else if (r < 310) begin
        step(1'b0, 1'b1, REG_STATUS, $urandom());
      end else if (r < 325) begin
        step(1'b0, 1'b1, REG_RSVD, $urandom());
      end else begin
        step(1'b0, 1'b0, 2'($urandom), $urandom());
      end
    end
    idle(80);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: transmit FIFO entries; power of two, 2..16.
REQ-002 Parameter DIV_RESET, default 16'd868: baud divisor loaded at reset, in clocks per bit.
REQ-003 Port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port we, input, 1: register write strobe, driven by the system address decoder's device write enable.
REQ-006 Port regsel, input, 2: register select, equal to addr[3:2] within the MMIO segment 0xffff0000-0xffff0010.
REQ-007 Port writedata, input, 32: CPU store data.
REQ-008 Port readdata, output, 32: combinational read value of the selected register, fed to the system read-data mux.
REQ-009 Port tx, output, 1: serial line, registered, idle high.

Function
REQ-010 Register map SHALL be: regsel 0 DATA (write-only, reads 0), 1 STATUS, 2 DIV, 3 reserved (reads 0, writes ignored).
REQ-011 A DATA write SHALL push writedata[7:0] into the FIFO at that edge when the FIFO is not full.
REQ-012 A DATA write while the FIFO is full SHALL be dropped and SHALL set sticky STATUS.ovf.
REQ-013 STATUS read SHALL be {24'b0, ovf[7], count[6:3], busy[2], full[1], empty[0]}, with count = FIFO occupancy.
REQ-014 A STATUS write with writedata[7]=1 SHALL clear ovf; all other STATUS write bits SHALL be ignored.
REQ-015 If a clearing write and an overflowing push occur in the same cycle, ovf SHALL be 1.
REQ-016 A DIV write SHALL load writedata[15:0]; value 0 SHALL be stored as 1; DIV reads SHALL return {16'b0, div}.
REQ-017 Serializer FSM SHALL have states IDLE, START, DATA, STOP; the frame is 8N1, LSB first.
REQ-018 In IDLE with the FIFO non-empty, the FSM SHALL pop at that edge, latch the byte and the current div, and enter START.
REQ-019 A DIV change SHALL affect only frames that start after the change.
REQ-020 tx SHALL be 1 in IDLE and STOP, 0 in START, and the current data bit in DATA.
REQ-021 Each of START, the 8 DATA bits, and STOP SHALL last exactly the latched div clocks.
REQ-022 A frame SHALL therefore occupy 10*div clocks on tx.
REQ-023 On leaving STOP, the FSM SHALL pop immediately when the FIFO is non-empty, with no idle gap; otherwise it SHALL go to IDLE.
REQ-024 Latency: for a DATA write at edge N into an empty FIFO with the FSM in IDLE, tx SHALL fall after edge N+1.
REQ-025 A push and a pop in the same cycle SHALL leave count unchanged and SHALL be allowed even when the FIFO is full.
REQ-026 busy SHALL be 1 whenever the FSM is not in IDLE.
REQ-027 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count width SHALL be log2(FIFO_DEPTH)+1.

Reset
REQ-028 On reset the block SHALL set: FSM=IDLE, tx=1, FIFO empty (count 0), ovf=0, div=DIV_RESET, bit counter 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame; tx SHALL read 1 after that edge, and queued bytes SHALL be discarded.
REQ-030 A DATA write coincident with reset SHALL be ignored.

Structure
REQ-031 Package mmio_pkg SHALL hold MMIO_BASE 32'hffff0000, MMIO_HIGH 32'hffff0010, the register-select constants, the STATUS bit positions and the FSM state enum.
REQ-032 The FIFO SHALL be a sub-module sync_fifo, parameterised on width and depth, with push/pop/full/empty/count ports.

Verification
REQ-033 Scenario: div=4, write DATA 0x55 -> tx shows 0, 1,0,1,0,1,0,1,0, 1, each bit held 4 clocks; busy returns to 0 after 40 clocks.
REQ-034 Scenario: div=2, five back-to-back DATA writes 0x01..0x05 with no pop possible -> the fifth write is dropped, ovf=1, full=1, count=4; 0x01..0x04 are sent in order with no inter-frame gap.
REQ-035 Scenario: write DIV=0 -> DIV reads 1; the next frame takes 10 clocks.
REQ-036 Scenario: DIV 4 changed to 8 mid-frame -> the current frame finishes at 4 clocks per bit; the next frame uses 8 clocks per bit.
REQ-037 Scenario: reset asserted during DATA bit 3 with 2 bytes queued -> tx=1, count=0, busy=0 after the reset edge, and no further frames are sent.
REQ-038 Scenario: STATUS clear (writedata=0x80) in the same cycle as a full-FIFO DATA write -> ovf remains 1.
